cpu_decode: RTL and testbench

//  Instruction decode stage. Consumes {opcode, operand, valid} from the instruction FIFO.

---
 rtl/cpu_decode_pkg.sv | 28 ++
 rtl/cpu_decode_rom.sv | 27 ++
 rtl/cpu_decode.sv | 100 ++++++++++
 tb/tb_cpu_decode.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_decode_pkg.sv
// cpu_decode_pkg: shared decode constants (op codes, form codes, imm32-op list, boot address) and types
package cpu_decode_pkg;
  localparam logic [31:0] BOOT_ADDRESS = 32'h0000_1000;
  localparam logic [1:0] FORM1 = 2'd0;
  localparam logic [1:0] FORM2 = 2'd2;
  localparam logic [1:0] FORM3 = 2'd3;
  localparam logic [5:0] OP_LDI  = 6'h01;
  localparam logic [5:0] OP_JSRA = 6'h03;
  localparam logic [5:0] OP_ADD  = 6'h05;
  localparam logic [5:0] OP_LDA  = 6'h08;
  localparam logic [5:0] OP_STA  = 6'h09;
  localparam logic [5:0] OP_LDO  = 6'h0C;
  localparam logic [5:0] OP_STO  = 6'h0D;
  localparam logic [5:0] OP_NOP  = 6'h0F;
  localparam logic [5:0] OP_TRAP = 6'h3F;
  localparam logic [7:0] F1_MAX  = 8'h35;
  localparam logic [3:0] F3_MAX  = 4'd9;
  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;
  typedef struct packed {
    logic [5:0] op;
    logic [1:0] form;
    logic       uses_imm32;
    logic       illegal;
  } rom_t;
  function automatic logic is_imm32(input logic [7:0] c);
    return c inside {8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D};
  endfunction
endpackage

// File: rtl/cpu_decode_rom.sv
// cpu_decode_rom: combinational opcode[15:8] -> {op, form, uses_imm32, illegal} lookup
//   opc_hi  in  8  upper byte of the raw instruction halfword
//   dec     out    decoded classification (rom_t)
//   CPU_DECODE_ILLEGAL_TRAP_EN: undefined codes become OP_TRAP with illegal set, else OP_NOP
module cpu_decode_rom
  import cpu_decode_pkg::*;
(
  input  logic [7:0] opc_hi,
  output rom_t       dec
);
  logic [5:0] raw;
  logic       undef;
  assign raw = !opc_hi[7] ? opc_hi[5:0] :
               !opc_hi[6] ? {4'b0, opc_hi[5:4]} : {2'b0, opc_hi[5:2]};
  // form2 uses all four codes; form3 defines codes 0..9 only
  assign undef = !opc_hi[7] ? (opc_hi == 8'h00 || opc_hi > F1_MAX) :
                 (opc_hi[6] && opc_hi[5:2] > F3_MAX);
  assign dec.form = opc_hi[7] ? opc_hi[7:6] : FORM1;
  assign dec.uses_imm32 = !opc_hi[7] && is_imm32(opc_hi);
`ifdef CPU_DECODE_ILLEGAL_TRAP_EN
  assign dec.op = undef ? OP_TRAP : raw;
  assign dec.illegal = undef;
`else
  assign dec.op = undef ? OP_NOP : raw;
  assign dec.illegal = 1'b0;
`endif
endmodule

// File: rtl/cpu_decode.sv
// cpu_decode: instruction decode stage with registered output bundle and 1-entry skid buffer
//   clk_i, rst_i (sync, active-high); opcode_i[15:0], operand_i[IMM_W-1:0], valid_i from FIFO
//   stall_o to fetch (registered, high while skid holds an instruction); uses_imm32_o comb
//   stall_i, flush_i from execute; valid_o, op_o, form_o, ra_o, rb_o, imm_o, illegal_o to execute
//   Optional: CPU_DECODE_ILLEGAL_TRAP_EN turns undefined opcodes into OP_TRAP with illegal_o=1
module cpu_decode
  import cpu_decode_pkg::*;
#(
  parameter int IMM_W = 32,
  parameter int OPC_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [15:0]      opcode_i,
  input  logic [IMM_W-1:0] operand_i,
  input  logic             valid_i,
  output logic             stall_o,
  output logic             uses_imm32_o,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic             valid_o,
  output logic [OPC_W-1:0] op_o,
  output logic [1:0]       form_o,
  output logic [3:0]       ra_o,
  output logic [3:0]       rb_o,
  output logic [IMM_W-1:0] imm_o,
  output logic             illegal_o
);
  localparam int BW = OPC_W + 2 + 4 + 4 + IMM_W + 1;
  localparam logic [BW-1:0] RST_B = {OPC_W'(OP_NOP), {(BW - OPC_W){1'b0}}};
  rom_t             rom;
  logic             accept;
  logic [3:0]       ra;
  logic [3:0]       rb;
  logic [IMM_W-1:0] imm;
  logic [BW-1:0]    dec;
  logic [BW-1:0]    out_q;
  logic [BW-1:0]    out_d;
  logic [BW-1:0]    skid_q;
  logic [BW-1:0]    skid_d;
  state_t           state_q;
  state_t           state_d;
  cpu_decode_rom u_rom (
    .opc_hi(opcode_i[15:8]),
    .dec   (rom)
  );
  assign accept = valid_i & !stall_o;
  assign uses_imm32_o = accept & rom.uses_imm32;
  assign ra = rom.form == FORM1 ? opcode_i[7:4] : rom.form == FORM2 ? opcode_i[11:8] : 4'd0;
  assign rb = rom.form == FORM1 ? opcode_i[3:0] : 4'd0;
  // form3 immediate is a halfword offset: sign-extend then scale by 2
  assign imm = rom.form == FORM2 ? IMM_W'(opcode_i[7:0]) :
               rom.form == FORM3 ? IMM_W'($signed({opcode_i[9:0], 1'b0})) :
               rom.uses_imm32 ? operand_i : '0;
  assign dec = {OPC_W'(rom.op), rom.form, ra, rb, imm, rom.illegal};
  assign {op_o, form_o, ra_o, rb_o, imm_o, illegal_o} = out_q;
  assign valid_o = state_q != ST_EMPTY;
  assign stall_o = state_q == ST_SKID;
  always_comb begin
    state_d = state_q;
    out_d = out_q;
    skid_d = skid_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
      skid_d = RST_B;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          state_d = accept ? ST_FULL : ST_EMPTY;
          out_d = accept ? dec : out_q;
        end
        ST_FULL: begin
          if (!stall_i) begin
            state_d = accept ? ST_FULL : ST_EMPTY;
            out_d = accept ? dec : out_q;
          end else if (accept) begin
            state_d = ST_SKID;
            skid_d = dec;
          end
        end
        ST_SKID: begin
          state_d = stall_i ? ST_SKID : ST_FULL;
          out_d = stall_i ? out_q : skid_q;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      out_q <= RST_B;
      skid_q <= RST_B;
    end else begin
      state_q <= state_d;
      out_q <= out_d;
      skid_q <= skid_d;
    end
  end
endmodule

// File: tb/tb_cpu_decode.sv
// tb_cpu_decode: directed and randomized checks of cpu_decode against a queue-based reference model
module tb_cpu_decode;
  import cpu_decode_pkg::*;
  logic        clk_i = 1'b0;
  logic        rst_i, valid_i, stall_i, flush_i;
  logic [15:0] opcode_i;
  logic [31:0] operand_i;
  logic        stall_o, uses_imm32_o, valid_o, illegal_o;
  logic [5:0]  op_o;
  logic [1:0]  form_o;
  logic [3:0]  ra_o, rb_o;
  logic [31:0] imm_o;
  int n_checks = 0;
  int n_pass = 0;
`ifdef CPU_DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  typedef struct packed {
    logic [5:0]  op;
    logic [1:0]  form;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [31:0] imm;
    logic        ill;
    logic        imm32;
  } exp_t;
  exp_t mq[$];
  cpu_decode dut (
    .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .operand_i(operand_i),
    .valid_i(valid_i), .stall_o(stall_o), .uses_imm32_o(uses_imm32_o),
    .stall_i(stall_i), .flush_i(flush_i), .valid_o(valid_o), .op_o(op_o),
    .form_o(form_o), .ra_o(ra_o), .rb_o(rb_o), .imm_o(imm_o), .illegal_o(illegal_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic exp_t ref_dec(input logic [15:0] o, input logic [31:0] w);
    exp_t e;
    int code;
    bit undef;
    e = '0;
    if (!o[15]) begin
      code = int'(o[15:8]);
      e.ra = o[7:4];
      e.rb = o[3:0];
      e.imm32 = code inside {1, 3, 8, 9, 12, 13};
      e.imm = e.imm32 ? w : 32'd0;
      undef = code == 0 || code > 'h35;
    end else if (!o[14]) begin
      code = int'(o[13:12]);
      e.form = 2'd2;
      e.ra = o[11:8];
      e.imm = 32'(o[7:0]);
      undef = 1'b0;
    end else begin
      code = int'(o[13:10]);
      e.form = 2'd3;
      e.imm = 32'(int'($signed(o[9:0])) * 2);
      undef = code > 9;
    end
    e.op = undef ? (TRAP_EN ? OP_TRAP : OP_NOP) : 6'(code);
    e.ill = undef && TRAP_EN;
    return e;
  endfunction
  task automatic tick();
    bit acc, pop;
    acc = valid_i && mq.size() < 2;
    pop = mq.size() > 0 && !stall_i;
    @(posedge clk_i);
    if (rst_i || flush_i) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(ref_dec(opcode_i, operand_i));
    end
    #1;
  endtask
  task automatic test_reset();
    rst_i = 1; valid_i = 1; stall_i = 0; flush_i = 0;
    opcode_i = 16'h0112; operand_i = $urandom;
    tick(); tick();
    n_checks++;
    if ({valid_o, stall_o} !== 2'b00) $display("FAIL reset_ctl got %b exp 00", {valid_o, stall_o});
    else n_pass++;
    n_checks++;
    if ({op_o, form_o, ra_o, rb_o, imm_o, illegal_o} !== {OP_NOP, 2'd0, 4'd0, 4'd0, 32'd0, 1'b0})
      $display("FAIL reset_bundle got %h exp %h", {op_o, form_o, ra_o, rb_o, imm_o, illegal_o},
               {OP_NOP, 2'd0, 4'd0, 4'd0, 32'd0, 1'b0});
    else n_pass++;
    rst_i = 0; valid_i = 0;
    tick();
    n_checks++;
    if ({valid_o, stall_o} !== 2'b00) $display("FAIL post_reset got %b exp 00", {valid_o, stall_o});
    else n_pass++;
  endtask
  task automatic test_ldi();
    opcode_i = 16'h0112; operand_i = 32'hDEADBEEF; valid_i = 1; stall_i = 0;
    #1;
    n_checks++;
    if (uses_imm32_o !== 1'b1) $display("FAIL ldi_uses_imm32 got %b exp 1", uses_imm32_o);
    else n_pass++;
    tick();
    valid_i = 0;
    n_checks++;
    if ({valid_o, op_o, form_o, ra_o, rb_o, imm_o} !== {1'b1, OP_LDI, 2'd0, 4'd1, 4'd2, 32'hDEADBEEF})
      $display("FAIL ldi_bundle got %h exp %h", {valid_o, op_o, form_o, ra_o, rb_o, imm_o},
               {1'b1, OP_LDI, 2'd0, 4'd1, 4'd2, 32'hDEADBEEF});
    else n_pass++;
    tick();
    n_checks++;
    if (valid_o !== 1'b0) $display("FAIL ldi_drain got %b exp 0", valid_o);
    else n_pass++;
  endtask
  task automatic test_forms();
    opcode_i = 16'hC3FF; operand_i = 32'h12345678; valid_i = 1; stall_i = 0;
    #1;
    n_checks++;
    if (uses_imm32_o !== 1'b0) $display("FAIL f3_uses_imm32 got %b exp 0", uses_imm32_o);
    else n_pass++;
    tick();
    opcode_i = 16'h8A7F;
    n_checks++;
    if ({valid_o, op_o, form_o, ra_o, rb_o, imm_o} !== {1'b1, 6'd0, 2'd3, 4'd0, 4'd0, 32'hFFFFFFFE})
      $display("FAIL form3 got %h exp %h", {valid_o, op_o, form_o, ra_o, rb_o, imm_o},
               {1'b1, 6'd0, 2'd3, 4'd0, 4'd0, 32'hFFFFFFFE});
    else n_pass++;
    tick();
    valid_i = 0;
    n_checks++;
    if ({valid_o, op_o, form_o, ra_o, rb_o, imm_o} !== {1'b1, 6'd0, 2'd2, 4'hA, 4'd0, 32'h7F})
      $display("FAIL form2 got %h exp %h", {valid_o, op_o, form_o, ra_o, rb_o, imm_o},
               {1'b1, 6'd0, 2'd2, 4'hA, 4'd0, 32'h7F});
    else n_pass++;
    tick();
  endtask
  task automatic test_back_to_back();
    opcode_i = 16'h0F00; valid_i = 1; stall_i = 0;
    tick();
    opcode_i = 16'h0523; stall_i = 1;
    tick();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({stall_o, valid_o, op_o, ra_o, rb_o} !== {1'b1, 1'b1, 6'h0F, 4'd0, 4'd0})
        $display("FAIL b2b_hold%0d got %h exp %h", k, {stall_o, valid_o, op_o, ra_o, rb_o},
                 {1'b1, 1'b1, 6'h0F, 4'd0, 4'd0});
      else n_pass++;
      if (k < 2) begin
        opcode_i = 16'h0177;
        tick();
      end
    end
    stall_i = 0; valid_i = 0;
    tick();
    n_checks++;
    if ({stall_o, valid_o, op_o, ra_o, rb_o} !== {1'b0, 1'b1, OP_ADD, 4'd2, 4'd3})
      $display("FAIL b2b_add got %h exp %h", {stall_o, valid_o, op_o, ra_o, rb_o},
               {1'b0, 1'b1, OP_ADD, 4'd2, 4'd3});
    else n_pass++;
    tick();
    n_checks++;
    if (valid_o !== 1'b0) $display("FAIL b2b_no_dup got %b exp 0", valid_o);
    else n_pass++;
  endtask
  task automatic test_flush();
    opcode_i = 16'h0201; valid_i = 1; stall_i = 0; flush_i = 0;
    tick();
    opcode_i = 16'h0234; stall_i = 1;
    tick();
    n_checks++;
    if (stall_o !== 1'b1) $display("FAIL flush_pre_skid got %b exp 1", stall_o);
    else n_pass++;
    flush_i = 1; opcode_i = 16'h0545;
    tick();
    flush_i = 0; valid_i = 0; stall_i = 0;
    n_checks++;
    if ({valid_o, stall_o} !== 2'b00) $display("FAIL flush_skid got %b exp 00", {valid_o, stall_o});
    else n_pass++;
    tick();
    n_checks++;
    if (valid_o !== 1'b0) $display("FAIL flush_no_emerge got %b exp 0", valid_o);
    else n_pass++;
    opcode_i = 16'h0201; valid_i = 1;
    tick();
    flush_i = 1; opcode_i = 16'h0300;
    tick();
    flush_i = 0; valid_i = 0;
    n_checks++;
    if ({valid_o, stall_o} !== 2'b00) $display("FAIL flush_full_drop got %b exp 00", {valid_o, stall_o});
    else n_pass++;
  endtask
  task automatic test_illegal();
    logic [15:0] ops[4] = '{16'h0000, 16'h3600, 16'hFC00, 16'h0F00};
    logic [5:0] eop[4];
    logic eill[4];
    for (int k = 0; k < 3; k++) begin
      eop[k] = TRAP_EN ? OP_TRAP : OP_NOP;
      eill[k] = TRAP_EN;
    end
    eop[3] = 6'h0F;
    eill[3] = 1'b0;
    stall_i = 0;
    for (int k = 0; k < 4; k++) begin
      opcode_i = ops[k]; valid_i = 1;
      tick();
      valid_i = 0;
      n_checks++;
      if ({valid_o, op_o, illegal_o} !== {1'b1, eop[k], eill[k]})
        $display("FAIL illegal_%h got %h exp %h", ops[k], {valid_o, op_o, illegal_o}, {1'b1, eop[k], eill[k]});
      else n_pass++;
      tick();
    end
  endtask
  task automatic test_random();
    exp_t e;
    logic [7:0] imm_ops[6] = '{8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D};
    for (int c = 0; c < 800; c++) begin
      rst_i = $urandom_range(0, 99) == 0;
      flush_i = $urandom_range(0, 15) == 0;
      valid_i = $urandom_range(0, 3) != 0;
      stall_i = $urandom_range(0, 2) == 0;
      opcode_i = 16'($urandom);
      if ($urandom_range(0, 2) == 0) opcode_i[15:8] = imm_ops[$urandom_range(0, 5)];
      operand_i = $urandom;
      #1;
      e = ref_dec(opcode_i, operand_i);
      n_checks++;
      if (uses_imm32_o !== (valid_i && mq.size() < 2 && e.imm32))
        $display("FAIL rnd_uses_imm32 c=%0d got %b exp %b", c, uses_imm32_o, valid_i && mq.size() < 2 && e.imm32);
      else n_pass++;
      tick();
      n_checks++;
      if ({valid_o, stall_o} !== {mq.size() > 0, mq.size() == 2})
        $display("FAIL rnd_ctl c=%0d got %b exp %b", c, {valid_o, stall_o}, {mq.size() > 0, mq.size() == 2});
      else n_pass++;
      if (mq.size() > 0) begin
        e = mq[0];
        n_checks++;
        if ({op_o, form_o, ra_o, rb_o, imm_o, illegal_o} !== {e.op, e.form, e.ra, e.rb, e.imm, e.ill})
          $display("FAIL rnd_bundle c=%0d got %h exp %h", c, {op_o, form_o, ra_o, rb_o, imm_o, illegal_o},
                   {e.op, e.form, e.ra, e.rb, e.imm, e.ill});
        else n_pass++;
      end
    end
    rst_i = 0; flush_i = 0; valid_i = 0; stall_i = 0;
  endtask
  initial begin
    test_reset();
    test_ldi();
    test_forms();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
